// File: rtl/msr_pkg.sv
// Shared constants and types for the timer-capture GPIO transfer path.
package msr_pkg;

  localparam int MSR_DATA_W = 24;
  localparam int MSR_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    ACK_LOW = 2'd3
  } tx_state_t;

  // Counter width that stays legal when the count range collapses to one value.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/msr_fifo.sv
// Synchronous fall-through FIFO: dout always shows the head word while not empty.
module msr_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] LVL_FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign full  = (r_level == LVL_FULL);
  assign empty = (r_level == '0);
  assign level = r_level;
  assign dout  = r_mem[r_rd_ptr];

  assign w_pop  = pop && !empty;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (w_pop && !w_push) r_level <= r_level - 1'b1;
    end
  end

endmodule

// File: rtl/msr_gpio_tx.sv
// Buffers captured timer words and ships them LSB-byte-first over an 8-bit
// GPIO bus using a four-phase strobe/ack handshake with an asynchronous Pi.
module msr_gpio_tx
  import msr_pkg::*;
#(
  parameter int DATA_W     = MSR_DATA_W,
  parameter int BYTE_W     = MSR_BYTE_W,
  parameter int FIFO_DEPTH = 4,
  parameter int SETUP_CYC  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic [BYTE_W-1:0]             gpio_data,
  output logic                          gpio_strobe,
  output logic                          gpio_last,
  input  logic                          gpio_ack,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clear_overflow
);

  localparam int NB    = DATA_W / BYTE_W;
  localparam int IDX_W = clog2_min1(NB);
  localparam int CNT_W = clog2_min1(SETUP_CYC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SETUP_CYC - 1);

  tx_state_t         r_state;
  logic [1:0]        r_ack_pipe;
  logic [DATA_W-1:0] r_shreg;
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_ack_s;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_dout;

  assign w_ack_s = r_ack_pipe[1];
  // A lingering ack from the Pi holds off the next word until it is released.
  assign w_pop   = (r_state == IDLE) && !w_empty && !w_ack_s;

  msr_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (w_pop),
    .din   (in_data),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_ack_pipe <= '0;
    else      r_ack_pipe <= {r_ack_pipe[0], gpio_ack};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (in_valid && w_full && !w_pop) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      gpio_data   <= '0;
      gpio_strobe <= 1'b0;
      gpio_last   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            gpio_data <= w_dout[BYTE_W-1:0];
            r_shreg   <= w_dout >> BYTE_W;
            gpio_last <= (LAST_IDX == '0);
            r_idx     <= '0;
            r_cnt     <= '0;
            r_state   <= SETUP;
          end
        end
        SETUP: begin
          if (r_cnt == CNT_MAX) begin
            gpio_strobe <= 1'b1;
            r_state     <= STROBE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STROBE: begin
          if (w_ack_s) begin
            gpio_strobe <= 1'b0;
            r_state     <= ACK_LOW;
          end
        end
        ACK_LOW: begin
          if (!w_ack_s) begin
            if (r_idx < LAST_IDX) begin
              gpio_data <= r_shreg[BYTE_W-1:0];
              r_shreg   <= r_shreg >> BYTE_W;
              gpio_last <= ((r_idx + 1'b1) == LAST_IDX);
              r_idx     <= r_idx + 1'b1;
              r_cnt     <= '0;
              r_state   <= SETUP;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msr_gpio_tx.sv
// Bench for msr_gpio_tx: a randomized Pi responder plus per-scenario tasks
// that compare the received byte stream against words split LSB first.
module tb_msr_gpio_tx;

  localparam int DATA_W = 24;
  localparam int BYTE_W = 8;
  localparam int DEPTH  = 4;
  localparam int SC     = 4;
  localparam int NB     = DATA_W / BYTE_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [BYTE_W-1:0] gpio_data;
  logic              gpio_strobe;
  logic              gpio_last;
  logic              gpio_ack;
  logic [2:0]        fifo_level;
  logic              overflow;
  logic              clear_overflow;

  always #5 clk = ~clk;

  msr_gpio_tx #(.DATA_W(DATA_W), .BYTE_W(BYTE_W), .FIFO_DEPTH(DEPTH), .SETUP_CYC(SC)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .gpio_data      (gpio_data),
    .gpio_strobe    (gpio_strobe),
    .gpio_last      (gpio_last),
    .gpio_ack       (gpio_ack),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  // Pi responder: records each byte at strobe, acks after a random delay,
  // then releases ack a random delay after strobe drops.
  logic       pi_hold = 1'b0;
  logic       pi_mute = 1'b0;
  int         pi_max  = 0;
  logic       pi_ack  = 1'b0;
  logic [7:0] rx_data [$];
  logic       rx_last [$];

  assign gpio_ack = pi_hold | pi_ack;

  initial begin : pi_model
    int st;
    int dly;
    st = 0;
    dly = 0;
    forever begin
      @(negedge clk);
      case (st)
        0: if (gpio_strobe && !pi_mute && !pi_hold) begin
             rx_data.push_back(gpio_data);
             rx_last.push_back(gpio_last);
             dly = $urandom_range(pi_max, 0);
             st = 1;
           end
        1: if (dly == 0) begin pi_ack = 1'b1; st = 2; end else dly--;
        2: if (!gpio_strobe) begin dly = $urandom_range(pi_max, 0); st = 3; end
        3: if (dly == 0) begin pi_ack = 1'b0; st = 0; end else dly--;
        default: st = 0;
      endcase
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [7:0] byte_of(input logic [DATA_W-1:0] w, input int i);
    return 8'(w >> (8 * i));
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int limit, output bit ok);
    int t;
    t = 0;
    while (rx_data.size() < n && t < limit) begin tick(); t++; end
    ok = (rx_data.size() >= n);
  endtask

  task automatic wait_quiet();
    int t;
    t = 0;
    while ((gpio_ack || gpio_strobe || fifo_level != 0) && t < 2000) begin tick(); t++; end
    repeat (10) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    n_cmp++; if (gpio_data !== 8'h00) begin n_err++; $display("FAIL reset_data got %h want 00", gpio_data); end
    n_cmp++; if (gpio_strobe !== 1'b0) begin n_err++; $display("FAIL reset_strobe got %b want 0", gpio_strobe); end
    n_cmp++; if (gpio_last !== 1'b0) begin n_err++; $display("FAIL reset_last got %b want 0", gpio_last); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b want 0", overflow); end
  endtask

  task automatic test_single();
    int base, lat, a, b;
    bit ok;
    logic [7:0] d;
    logic [DATA_W-1:0] w;
    w = 24'hA1B2C3;
    pi_max = 0;
    base = rx_data.size();
    push_word(w);
    lat = 1;
    while (!gpio_strobe && lat < 50) begin tick(); lat++; end
    n_cmp++; if (lat != 2 + SC) begin n_err++; $display("FAIL single_latency got %0d want %0d", lat, 2 + SC); end
    a = 0;
    while (!gpio_ack && a < 20) begin tick(); a++; end
    a = 0;
    while (gpio_strobe && a < 20) begin tick(); a++; end
    n_cmp++; if (a != 3) begin n_err++; $display("FAIL ack_to_strobe_fall got %0d want 3", a); end
    b = 0;
    while (gpio_ack && b < 20) begin tick(); b++; end
    d = gpio_data;
    b = 0;
    while (gpio_data === d && b < 20) begin tick(); b++; end
    n_cmp++; if (b != 3) begin n_err++; $display("FAIL ack_fall_to_setup got %0d want 3", b); end
    wait_bytes(base + NB, 500, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL single_timeout got %0d bytes want %0d", rx_data.size() - base, NB); end
    if (ok) for (int i = 0; i < NB; i++) begin
      n_cmp++;
      if (rx_data[base+i] !== byte_of(w, i) || rx_last[base+i] !== (i == NB - 1)) begin
        n_err++;
        $display("FAIL single_byte%0d got %h/%b want %h/%b", i, rx_data[base+i], rx_last[base+i], byte_of(w, i), i == NB - 1);
      end
    end
    wait_quiet();
  endtask

  task automatic test_burst();
    int base;
    bit ok;
    pi_max = 2;
    pi_hold = 1'b1;
    repeat (3) tick();
    base = rx_data.size();
    for (int i = 1; i <= 5; i++) push_word(24'(i));
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL burst_overflow got %b want 1", overflow); end
    n_cmp++; if (fifo_level !== 3'd4) begin n_err++; $display("FAIL burst_level got %0d want 4", fifo_level); end
    pi_hold = 1'b0;
    wait_bytes(base + 4 * NB, 3000, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL burst_timeout got %0d bytes want 12", rx_data.size() - base); end
    if (ok) for (int i = 0; i < 4 * NB; i++) begin
      n_cmp++;
      if (rx_data[base+i] !== byte_of(24'(i / NB + 1), i % NB) || rx_last[base+i] !== (i % NB == NB - 1)) begin
        n_err++;
        $display("FAIL burst_byte%0d got %h/%b want %h/%b", i, rx_data[base+i], rx_last[base+i], byte_of(24'(i / NB + 1), i % NB), i % NB == NB - 1);
      end
    end
    wait_quiet();
    n_cmp++; if (rx_data.size() != base + 4 * NB) begin n_err++; $display("FAIL burst_extra got %0d bytes want 12", rx_data.size() - base); end
  endtask

  task automatic test_ovf_clear();
    int base;
    bit ok;
    logic [DATA_W-1:0] words [$];
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b want 0", overflow); end
    pi_hold = 1'b1;
    repeat (3) tick();
    base = rx_data.size();
    for (int i = 0; i < 4; i++) begin
      words.push_back(24'($urandom));
      push_word(words[i]);
    end
    push_word(24'h5A5A5A);
    clear_overflow = 1'b1;
    push_word(24'hA5A5A5);
    clear_overflow = 1'b0;
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set_wins got %b want 1", overflow); end
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear2 got %b want 0", overflow); end
    pi_hold = 1'b0;
    wait_bytes(base + 4 * NB, 3000, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL ovf_timeout got %0d bytes want 12", rx_data.size() - base); end
    if (ok) for (int i = 0; i < 4 * NB; i++) begin
      n_cmp++;
      if (rx_data[base+i] !== byte_of(words[i/NB], i % NB)) begin
        n_err++;
        $display("FAIL ovf_byte%0d got %h want %h", i, rx_data[base+i], byte_of(words[i/NB], i % NB));
      end
    end
    wait_quiet();
    n_cmp++; if (rx_data.size() != base + 4 * NB) begin n_err++; $display("FAIL ovf_extra got %0d bytes want 12", rx_data.size() - base); end
  endtask

  // Streams random words with slow random acks, watching the bus every cycle.
  task automatic test_handshake();
    localparam int N = 8;
    int base, pushed, started, t;
    logic [DATA_W-1:0] words [$];
    logic [7:0] prev_data;
    logic prev_stb;
    logic [2:0] ack_hist;
    pi_max = 50;
    base = rx_data.size();
    pushed = 0;
    t = 0;
    prev_data = gpio_data;
    prev_stb = gpio_strobe;
    ack_hist = '0;
    while ((pushed < N || rx_data.size() < base + N * NB) && t < 8000) begin
      started = (rx_data.size() - base + NB - 1) / NB;
      if (pushed < N && pushed - started < DEPTH && $urandom_range(3, 0) == 0) begin
        words.push_back(24'($urandom));
        in_valid = 1'b1;
        in_data = words[pushed];
        pushed++;
      end
      tick();
      in_valid = 1'b0;
      t++;
      if (gpio_data !== prev_data) begin
        n_cmp++;
        if (prev_stb || gpio_strobe || ack_hist != 3'b000) begin
          n_err++;
          $display("FAIL hs_data_change got %h->%h stb=%b ack_hist=%b want stable", prev_data, gpio_data, gpio_strobe, ack_hist);
        end
      end
      if (gpio_strobe && !prev_stb) begin
        n_cmp++;
        if (ack_hist != 3'b000 || gpio_ack) begin
          n_err++;
          $display("FAIL hs_strobe_rerise got ack_hist=%b ack=%b want 000/0", ack_hist, gpio_ack);
        end
      end
      prev_data = gpio_data;
      prev_stb = gpio_strobe;
      ack_hist = {ack_hist[1:0], gpio_ack};
    end
    n_cmp++; if (rx_data.size() < base + N * NB) begin n_err++; $display("FAIL hs_timeout got %0d bytes want %0d", rx_data.size() - base, N * NB); end
    else for (int i = 0; i < N * NB; i++) begin
      n_cmp++;
      if (rx_data[base+i] !== byte_of(words[i/NB], i % NB) || rx_last[base+i] !== (i % NB == NB - 1)) begin
        n_err++;
        $display("FAIL hs_byte%0d got %h/%b want %h/%b", i, rx_data[base+i], rx_last[base+i], byte_of(words[i/NB], i % NB), i % NB == NB - 1);
      end
    end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL hs_overflow got %b want 0", overflow); end
    pi_max = 2;
    wait_quiet();
  endtask

  task automatic test_reset_mid();
    int base, t;
    bit rose;
    pi_mute = 1'b1;
    base = rx_data.size();
    for (int i = 0; i < 3; i++) push_word(24'($urandom));
    t = 0;
    while (!gpio_strobe && t < 50) begin tick(); t++; end
    n_cmp++; if (gpio_strobe !== 1'b1) begin n_err++; $display("FAIL rstmid_strobe_up got %b want 1", gpio_strobe); end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (gpio_strobe !== 1'b0) begin n_err++; $display("FAIL rstmid_async_drop got %b want 0", gpio_strobe); end
    repeat (2) tick();
    rst = 1'b1;
    tick();
    n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL rstmid_level got %0d want 0", fifo_level); end
    n_cmp++; if (gpio_data !== 8'h00 || gpio_last !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_outputs got data=%h last=%b ovf=%b want 00/0/0", gpio_data, gpio_last, overflow);
    end
    pi_mute = 1'b0;
    rose = 1'b0;
    for (int i = 0; i < 60; i++) begin tick(); if (gpio_strobe) rose = 1'b1; end
    n_cmp++; if (rose || rx_data.size() != base) begin
      n_err++;
      $display("FAIL rstmid_no_tx got strobe=%b bytes=%0d want 0/0", rose, rx_data.size() - base);
    end
  endtask

  task automatic test_wrap();
    localparam int N = 10;
    int base, pushed, started, t;
    logic [DATA_W-1:0] words [$];
    pi_max = 3;
    base = rx_data.size();
    pushed = 0;
    t = 0;
    while ((pushed < N || rx_data.size() < base + N * NB) && t < 6000) begin
      started = (rx_data.size() - base + NB - 1) / NB;
      if (pushed < N && pushed - started < DEPTH && $urandom_range(1, 0) == 0) begin
        words.push_back(24'h00FF00 | 24'($urandom_range(255, 0)) | 24'h00FF0000 >> 8);
        in_valid = 1'b1;
        in_data = words[pushed];
        pushed++;
      end
      tick();
      in_valid = 1'b0;
      t++;
    end
    n_cmp++; if (rx_data.size() < base + N * NB) begin n_err++; $display("FAIL wrap_timeout got %0d bytes want %0d", rx_data.size() - base, N * NB); end
    else for (int i = 0; i < N * NB; i++) begin
      n_cmp++;
      if (rx_data[base+i] !== byte_of(words[i/NB], i % NB) || rx_last[base+i] !== (i % NB == NB - 1)) begin
        n_err++;
        $display("FAIL wrap_byte%0d got %h/%b want %h/%b", i, rx_data[base+i], rx_last[base+i], byte_of(words[i/NB], i % NB), i % NB == NB - 1);
      end
    end
    wait_quiet();
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL wrap_overflow got %b want 0", overflow); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL wrap_level got %0d want 0", fifo_level); end
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    clear_overflow = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_ovf_clear();
    test_handshake();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
